// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
package mem_arbiter_pkg;

  // RUN: both ports arbitrated; DRAIN: wait out in-flight reads; LOAD: loader owns memory
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Port indices into the two-bit request/grant vectors
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the arbiter and the RAM.
// Signal names follow the arbiter's point of view (i_ into it, o_ out of it).
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  logic          i_cpu_req;
  logic          i_cpu_we;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_gnt;
  logic          o_cpu_rvalid;
  logic [DW-1:0] o_cpu_rdata;
  logic          o_cpu_stall;

  logic          i_ldr_req;
  logic          i_ldr_we;
  logic [AW-1:0] i_ldr_addr;
  logic [DW-1:0] i_ldr_wdata;
  logic          o_ldr_gnt;
  logic          o_ldr_rvalid;
  logic [DW-1:0] o_ldr_rdata;
  logic          i_ldr_lock;

  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata, i_ldr_lock,
    input  i_mem_rdata,
    output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata, o_cpu_stall,
    output o_ldr_gnt, o_ldr_rvalid, o_ldr_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata, i_ldr_lock,
    output i_mem_rdata,
    input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata, o_cpu_stall,
    input  o_ldr_gnt, o_ldr_rvalid, o_ldr_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a 1-bit last-granted pointer.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_ptr_ldr,
  output logic [1:0] o_gnt
);

  logic r_last;

  // A lone requester always wins; on a tie the port not granted last wins
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT_CPU] && (!i_req[PORT_LDR] || r_last == PORT_LDR)) begin
      o_gnt[PORT_CPU] = 1'b1;
    end else if (i_req[PORT_LDR]) begin
      o_gnt[PORT_LDR] = 1'b1;
    end
  end

  // Track the last winner; reset and forced loads leave the CPU favoured
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_last <= PORT_LDR;
    end else if (i_ptr_ldr || o_gnt[PORT_LDR]) begin
      r_last <= PORT_LDR;
    end else if (o_gnt[PORT_CPU]) begin
      r_last <= PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/loader arbiter for a single-port synchronous RAM with a loader lock mode.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_ptr_ldr;
  logic          r_cpu_rvalid;
  logic          r_ldr_rvalid;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          w_cpu_rvalid;
  logic          w_ldr_rvalid;
  logic [AW-1:0] w_mem_addr;

  rr_arb2 u_rr_arb2 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (w_req),
    .i_ptr_ldr (w_ptr_ldr),
    .o_gnt     (w_gnt)
  );

  // Next state and the per-state request mask fed to the round-robin
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 2'b00;
    w_ptr_ldr   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // CPU is blocked in the cycle lock is first seen so it cannot slip in
        w_req[PORT_CPU] = bus.i_cpu_req & ~bus.i_ldr_lock;
        w_req[PORT_LDR] = bus.i_ldr_req;
        if (bus.i_ldr_lock) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.i_ldr_lock) begin
          w_state_nxt = ST_RUN;
        end else if (!(r_cpu_rvalid || r_ldr_rvalid)) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_req[PORT_LDR] = bus.i_ldr_req;
        if (!bus.i_ldr_lock) begin
          w_state_nxt = ST_RUN;
          w_ptr_ldr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (!i_rst) w_req = 2'b00;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Read-return tracking: rvalid one cycle after a read grant, rdata held afterwards
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_gnt[PORT_CPU] & ~bus.i_cpu_we;
      r_ldr_rvalid <= w_gnt[PORT_LDR] & ~bus.i_ldr_we;
      if (r_cpu_rvalid) r_cpu_rdata <= bus.i_mem_rdata;
      if (r_ldr_rvalid) r_ldr_rdata <= bus.i_mem_rdata;
    end
  end

  // Reset low in the return cycle kills a pending rvalid immediately
  assign w_cpu_rvalid = r_cpu_rvalid & i_rst;
  assign w_ldr_rvalid = r_ldr_rvalid & i_rst;
  assign w_mem_addr   = w_gnt[PORT_LDR] ? bus.i_ldr_addr : bus.i_cpu_addr;

  assign bus.o_cpu_gnt    = w_gnt[PORT_CPU];
  assign bus.o_ldr_gnt    = w_gnt[PORT_LDR];
  assign bus.o_cpu_rvalid = w_cpu_rvalid;
  assign bus.o_ldr_rvalid = w_ldr_rvalid;
  // RAM data is already registered, so the return cycle passes it straight through
  assign bus.o_cpu_rdata  = w_cpu_rvalid ? bus.i_mem_rdata : r_cpu_rdata;
  assign bus.o_ldr_rdata  = w_ldr_rvalid ? bus.i_mem_rdata : r_ldr_rdata;
  assign bus.o_cpu_stall  = (r_state != ST_RUN);

  assign bus.o_mem_en    = |w_gnt;
  assign bus.o_mem_we    = (w_gnt[PORT_CPU] & bus.i_cpu_we) | (w_gnt[PORT_LDR] & bus.i_ldr_we);
  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_wdata = w_gnt[PORT_LDR] ? bus.i_ldr_wdata : bus.i_cpu_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port synchronous RAM.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] mem [256];

  mem_arbiter_if #(.AW(8), .DW(8)) bus_if ();

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-first, data registered one cycle after en
  always @(posedge clk) begin
    if (bus_if.o_mem_en) begin
      if (bus_if.o_mem_we) mem[bus_if.o_mem_addr] <= bus_if.o_mem_wdata;
      bus_if.i_mem_rdata <= mem[bus_if.o_mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus_if.i_cpu_req = req; bus_if.i_cpu_we = we; bus_if.i_cpu_addr = addr; bus_if.i_cpu_wdata = wdata;
  endtask

  task automatic drive_ldr(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus_if.i_ldr_req = req; bus_if.i_ldr_we = we; bus_if.i_ldr_addr = addr; bus_if.i_ldr_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_cpu(1'b1, 1'b1, 8'h10, 8'h77);
    drive_ldr(1'b1, 1'b0, 8'h20, 8'h00);
    step(); step(); #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b0) begin failures++; $display("FAIL rst_cpu_gnt got=%b exp=0", bus_if.o_cpu_gnt); end
    checks++; if (bus_if.o_ldr_gnt !== 1'b0) begin failures++; $display("FAIL rst_ldr_gnt got=%b exp=0", bus_if.o_ldr_gnt); end
    checks++; if (bus_if.o_mem_en !== 1'b0 || bus_if.o_mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_en_we got=%b%b exp=00", bus_if.o_mem_en, bus_if.o_mem_we); end
    checks++; if (bus_if.o_cpu_rvalid !== 1'b0 || bus_if.o_ldr_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", bus_if.o_cpu_rvalid, bus_if.o_ldr_rvalid); end
    checks++; if (bus_if.o_cpu_rdata !== 8'h00 || bus_if.o_ldr_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=00/00", bus_if.o_cpu_rdata, bus_if.o_ldr_rdata); end
    checks++; if (bus_if.o_cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus_if.o_cpu_stall); end
  endtask

  task automatic test_cpu_read();
    step();
    rst = 1'b1;
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    drive_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b exp=1", bus_if.o_cpu_gnt); end
    checks++; if (bus_if.o_mem_en !== 1'b1 || bus_if.o_mem_addr !== 8'h10 || bus_if.o_mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem got en=%b addr=%h we=%b exp en=1 addr=10 we=0", bus_if.o_mem_en, bus_if.o_mem_addr, bus_if.o_mem_we); end
    step();
    drive_cpu(1'b0, 1'b0, 8'h10, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'h5A) begin failures++; $display("FAIL rd_rvalid got=%b data=%h exp=1 data=5a", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata); end
    checks++; if (bus_if.o_ldr_rvalid !== 1'b0) begin failures++; $display("FAIL rd_ldr_rvalid got=%b exp=0", bus_if.o_ldr_rvalid); end
    step(); #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", bus_if.o_cpu_rvalid); end
    step();
  endtask

  task automatic test_round_robin();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
        drive_ldr(1'b1, 1'b0, 8'h20, 8'h00);
      end else begin
        drive_cpu(1'b0, 1'b0, 8'h10, 8'h00);
        drive_ldr(1'b0, 1'b0, 8'h20, 8'h00);
      end
      #2;
      if (i < 4) begin
        checks++;
        if (bus_if.o_cpu_gnt !== (i % 2 == 0) || bus_if.o_ldr_gnt !== (i % 2 == 1)) begin
          failures++; $display("FAIL rr_gnt cycle=%0d got cpu=%b ldr=%b exp cpu=%b ldr=%b", i, bus_if.o_cpu_gnt, bus_if.o_ldr_gnt, (i % 2 == 0), (i % 2 == 1));
        end
      end
      if (i > 0) begin
        checks++;
        if ((i % 2 == 1) ? (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_ldr_rvalid !== 1'b0 || bus_if.o_cpu_rdata !== 8'h5A)
                         : (bus_if.o_ldr_rvalid !== 1'b1 || bus_if.o_cpu_rvalid !== 1'b0 || bus_if.o_ldr_rdata !== 8'hA5)) begin
          failures++; $display("FAIL rr_rvalid cycle=%0d got cpu=%b/%h ldr=%b/%h", i, bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata, bus_if.o_ldr_rvalid, bus_if.o_ldr_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_write_read();
    drive_cpu(1'b1, 1'b1, 8'hFF, 8'hC3);
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1 || bus_if.o_mem_we !== 1'b1 || bus_if.o_mem_addr !== 8'hFF || bus_if.o_mem_wdata !== 8'hC3) begin failures++; $display("FAIL wr_cycle got gnt=%b we=%b addr=%h wdata=%h exp 1 1 ff c3", bus_if.o_cpu_gnt, bus_if.o_mem_we, bus_if.o_mem_addr, bus_if.o_mem_wdata); end
    step();
    drive_cpu(1'b1, 1'b0, 8'hFF, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1 || bus_if.o_mem_we !== 1'b0 || bus_if.o_cpu_rvalid !== 1'b0) begin failures++; $display("FAIL raw_read got gnt=%b we=%b rvalid=%b exp 1 0 0", bus_if.o_cpu_gnt, bus_if.o_mem_we, bus_if.o_cpu_rvalid); end
    step();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'hC3 || bus_if.o_mem_we !== 1'b0) begin failures++; $display("FAIL raw_data got rvalid=%b data=%h we=%b exp 1 c3 0", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata, bus_if.o_mem_we); end
    step();
  endtask

  task automatic test_lock_drain();
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    bus_if.i_ldr_lock = 1'b0;
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1) begin failures++; $display("FAIL lk_pre_gnt got=%b exp=1", bus_if.o_cpu_gnt); end
    step();
    drive_cpu(1'b1, 1'b0, 8'h00, 8'h00);
    bus_if.i_ldr_lock = 1'b1;
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'h5A) begin failures++; $display("FAIL lk_rvalid got=%b data=%h exp=1 5a", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata); end
    checks++; if (bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_cpu_stall !== 1'b0) begin failures++; $display("FAIL lk_run_cycle got gnt=%b stall=%b exp 0 0", bus_if.o_cpu_gnt, bus_if.o_cpu_stall); end
    step();
    drive_ldr(1'b1, 1'b0, 8'h20, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_stall !== 1'b1 || bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_ldr_gnt !== 1'b0) begin failures++; $display("FAIL lk_drain got stall=%b cgnt=%b lgnt=%b exp 1 0 0", bus_if.o_cpu_stall, bus_if.o_cpu_gnt, bus_if.o_ldr_gnt); end
    step(); #2;
    checks++; if (bus_if.o_cpu_stall !== 1'b1 || bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_ldr_gnt !== 1'b1) begin failures++; $display("FAIL lk_load got stall=%b cgnt=%b lgnt=%b exp 1 0 1", bus_if.o_cpu_stall, bus_if.o_cpu_gnt, bus_if.o_ldr_gnt); end
    step();
    drive_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_ldr_rvalid !== 1'b1 || bus_if.o_ldr_rdata !== 8'hA5 || bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_cpu_rvalid !== 1'b0) begin failures++; $display("FAIL lk_ldr_read got lrv=%b ldata=%h cgnt=%b crv=%b exp 1 a5 0 0", bus_if.o_ldr_rvalid, bus_if.o_ldr_rdata, bus_if.o_cpu_gnt, bus_if.o_cpu_rvalid); end
    step();
  endtask

  task automatic test_loader_load();
    for (int k = 0; k < 4; k++) begin
      drive_ldr(1'b1, 1'b1, 8'(k), 8'(k + 1));
      #2;
      checks++;
      if (bus_if.o_ldr_gnt !== 1'b1 || bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_mem_we !== 1'b1 || bus_if.o_mem_addr !== 8'(k) || bus_if.o_mem_wdata !== 8'(k + 1)) begin
        failures++; $display("FAIL ld_write k=%0d got lgnt=%b cgnt=%b we=%b addr=%h wdata=%h", k, bus_if.o_ldr_gnt, bus_if.o_cpu_gnt, bus_if.o_mem_we, bus_if.o_mem_addr, bus_if.o_mem_wdata);
      end
      step();
    end
    drive_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    bus_if.i_ldr_lock = 1'b0;
    #2;
    checks++; if (bus_if.o_cpu_stall !== 1'b1 || bus_if.o_cpu_gnt !== 1'b0) begin failures++; $display("FAIL ld_unlock got stall=%b cgnt=%b exp 1 0", bus_if.o_cpu_stall, bus_if.o_cpu_gnt); end
    step();
    drive_ldr(1'b1, 1'b0, 8'h01, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1 || bus_if.o_ldr_gnt !== 1'b0 || bus_if.o_cpu_stall !== 1'b0) begin failures++; $display("FAIL ld_cpu_first got cgnt=%b lgnt=%b stall=%b exp 1 0 0", bus_if.o_cpu_gnt, bus_if.o_ldr_gnt, bus_if.o_cpu_stall); end
    step();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'h01 || bus_if.o_ldr_gnt !== 1'b1) begin failures++; $display("FAIL ld_readback got rv=%b data=%h lgnt=%b exp 1 01 1", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata, bus_if.o_ldr_gnt); end
    step();
    drive_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_ldr_rvalid !== 1'b1 || bus_if.o_ldr_rdata !== 8'h02) begin failures++; $display("FAIL ld_ldr_readback got rv=%b data=%h exp 1 02", bus_if.o_ldr_rvalid, bus_if.o_ldr_rdata); end
    step();
  endtask

  task automatic test_drain_abort();
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    bus_if.i_ldr_lock = 1'b1;
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b0) begin failures++; $display("FAIL ab_lock_gnt got=%b exp=0", bus_if.o_cpu_gnt); end
    step();
    bus_if.i_ldr_lock = 1'b0;
    #2;
    checks++; if (bus_if.o_cpu_stall !== 1'b1 || bus_if.o_cpu_gnt !== 1'b0) begin failures++; $display("FAIL ab_drain got stall=%b gnt=%b exp 1 0", bus_if.o_cpu_stall, bus_if.o_cpu_gnt); end
    step(); #2;
    checks++; if (bus_if.o_cpu_stall !== 1'b0 || bus_if.o_cpu_gnt !== 1'b1) begin failures++; $display("FAIL ab_run got stall=%b gnt=%b exp 0 1", bus_if.o_cpu_stall, bus_if.o_cpu_gnt); end
    step();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'h5A) begin failures++; $display("FAIL ab_rvalid got=%b data=%h exp 1 5a", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata); end
    step();
  endtask

  task automatic test_reset_mid_read();
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1) begin failures++; $display("FAIL mr_gnt got=%b exp=1", bus_if.o_cpu_gnt); end
    step();
    rst = 1'b0;
    drive_ldr(1'b1, 1'b0, 8'h20, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b0) begin failures++; $display("FAIL mr_rvalid got=%b exp=0", bus_if.o_cpu_rvalid); end
    checks++; if (bus_if.o_cpu_gnt !== 1'b0 || bus_if.o_ldr_gnt !== 1'b0 || bus_if.o_mem_en !== 1'b0) begin failures++; $display("FAIL mr_gnts got c=%b l=%b en=%b exp 0 0 0", bus_if.o_cpu_gnt, bus_if.o_ldr_gnt, bus_if.o_mem_en); end
    step(); #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b0 || bus_if.o_ldr_rvalid !== 1'b0) begin failures++; $display("FAIL mr_rvalid2 got=%b%b exp=00", bus_if.o_cpu_rvalid, bus_if.o_ldr_rvalid); end
    step();
    rst = 1'b1;
    #2;
    checks++; if (bus_if.o_cpu_gnt !== 1'b1 || bus_if.o_ldr_gnt !== 1'b0 || bus_if.o_cpu_stall !== 1'b0) begin failures++; $display("FAIL mr_after got cgnt=%b lgnt=%b stall=%b exp 1 0 0", bus_if.o_cpu_gnt, bus_if.o_ldr_gnt, bus_if.o_cpu_stall); end
    step();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    checks++; if (bus_if.o_cpu_rvalid !== 1'b1 || bus_if.o_cpu_rdata !== 8'h5A) begin failures++; $display("FAIL mr_read got=%b data=%h exp 1 5a", bus_if.o_cpu_rvalid, bus_if.o_cpu_rdata); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'hA5;
    bus_if.i_mem_rdata = 8'h00;
    bus_if.i_ldr_lock  = 1'b0;
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_write_read();
    test_lock_drain();
    test_loader_load();
    test_drain_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
